// File: rtl/ulpi_csr_pkg.sv
// Shared definitions for the ULPI CSR bridge: register map, AXI response codes,
// FSM states and the CSR address decoder.
package ulpi_csr_pkg;

  localparam logic [11:0] OFS_ID      = 12'h000;
  localparam logic [11:0] OFS_STATUS  = 12'h004;
  localparam logic [11:0] OFS_SCRATCH = 12'h008;
  localparam logic [3:0]  WIN_PAGE    = 4'h1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ULPI,
    ST_BRESP,
    ST_RRESP
  } state_t;

  typedef enum logic [2:0] {
    DEC_ID,
    DEC_STATUS,
    DEC_SCRATCH,
    DEC_WIN,
    DEC_ERR
  } dec_t;

  // Byte-lane bits [1:0] are ignored; 0x100-0x1FF is the PHY register window.
  function automatic dec_t addr_decode(input logic [11:0] addr);
    logic [11:0] a;
    dec_t        d;
    a = {addr[11:2], 2'b00};
    if (a[11:8] == WIN_PAGE) begin
      d = DEC_WIN;
    end else begin
      case (a)
        OFS_ID:      d = DEC_ID;
        OFS_STATUS:  d = DEC_STATUS;
        OFS_SCRATCH: d = DEC_SCRATCH;
        default:     d = DEC_ERR;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/ulpi_csr_bridge.sv
// AXI4-Lite CSR slave: local ID/STATUS/SCRATCH registers plus a 64-entry window
// onto ULPI PHY registers; each PHY access is bounded by TIMEOUT_CYCLES.
module ulpi_csr_bridge
  import ulpi_csr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ID_VALUE       = 32'h554C_5049
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        reg_req,
  output logic        reg_we,
  output logic [5:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic        reg_ack,
  input  logic [7:0]  reg_rdata
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        awready_q, awready_d;
  logic        arready_q, arready_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tocnt_q, tocnt_d;
  logic [31:0] scratch_q, scratch_d;

  logic        wr_hs, rd_hs;
  dec_t        wr_dec, rd_dec;
  logic [1:0]  done_resp;
  logic [31:0] done_rdata;
  logic        unused_ok;

  assign unused_ok = ^{s_axi_awaddr[31:12], s_axi_araddr[31:12], s_axi_awprot, s_axi_arprot};

  // Ready is only ever raised while the matching valid(s) are high, so the
  // handshake lands on the cycle after ready rises.
  assign wr_hs  = awready_q && s_axi_awvalid && s_axi_wvalid;
  assign rd_hs  = arready_q && s_axi_arvalid;
  assign wr_dec = addr_decode(s_axi_awaddr[11:0]);
  assign rd_dec = addr_decode(s_axi_araddr[11:0]);

  always_comb begin
    state_d    = state_q;
    awready_d  = 1'b0;
    arready_d  = 1'b0;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    bresp_d    = bresp_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    tocnt_d    = tocnt_q;
    scratch_d  = scratch_q;
    done_resp  = RESP_OKAY;
    done_rdata = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (wr_hs) begin
          state_d  = ST_BRESP;
          bvalid_d = 1'b1;
          bresp_d  = RESP_OKAY;
          case (wr_dec)
            DEC_SCRATCH: begin
              for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) scratch_d[8*b +: 8] = s_axi_wdata[8*b +: 8];
              end
            end
            DEC_WIN: begin
              if (s_axi_wstrb[0]) begin
                state_d  = ST_ULPI;
                bvalid_d = 1'b0;
                req_d    = 1'b1;
                we_d     = 1'b1;
                addr_d   = s_axi_awaddr[7:2];
                wdata_d  = s_axi_wdata[7:0];
                cnt_d    = 16'h0;
              end
            end
            DEC_ERR: bresp_d = RESP_DECERR;
            default: ;
          endcase
        end else if (rd_hs) begin
          state_d  = ST_RRESP;
          rvalid_d = 1'b1;
          rresp_d  = RESP_OKAY;
          case (rd_dec)
            DEC_ID:      rdata_d = ID_VALUE;
            DEC_STATUS:  rdata_d = {16'h0, tocnt_q, 7'h0, state_q != ST_IDLE};
            DEC_SCRATCH: rdata_d = scratch_q;
            DEC_WIN: begin
              state_d  = ST_ULPI;
              rvalid_d = 1'b0;
              req_d    = 1'b1;
              we_d     = 1'b0;
              addr_d   = s_axi_araddr[7:2];
              cnt_d    = 16'h0;
            end
            default: begin
              rresp_d = RESP_DECERR;
              rdata_d = 32'h0;
            end
          endcase
        end else if (s_axi_awvalid && s_axi_wvalid) begin
          awready_d = 1'b1;
        end else if (s_axi_arvalid) begin
          arready_d = 1'b1;
        end
      end

      ST_ULPI: begin
        // An ack arriving in the expiry cycle still wins over the timeout.
        if (reg_ack || cnt_q == CNT_LAST) begin
          req_d = 1'b0;
          if (reg_ack) begin
            done_resp  = RESP_OKAY;
            done_rdata = {24'h0, reg_rdata};
          end else begin
            done_resp  = RESP_SLVERR;
            done_rdata = 32'h0;
            if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
          end
          if (we_q) begin
            state_d  = ST_BRESP;
            bvalid_d = 1'b1;
            bresp_d  = done_resp;
          end else begin
            state_d  = ST_RRESP;
            rvalid_d = 1'b1;
            rresp_d  = done_resp;
            rdata_d  = done_rdata;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_BRESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      ST_RRESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 6'h0;
      wdata_q   <= 8'h0;
      cnt_q     <= 16'h0;
      tocnt_q   <= 8'h0;
      scratch_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      tocnt_q   <= tocnt_d;
      scratch_q <= scratch_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign reg_req       = req_q;
  assign reg_we        = we_q;
  assign reg_addr      = addr_q;
  assign reg_wdata     = wdata_q;

endmodule

// File: doc/ulpi_csr_bridge.md
# ulpi_csr_bridge

AXI4-Lite slave that terminates the debug CSR bus and converts accesses into ULPI PHY register transactions. Sits between the JTAG-to-AXI master and the ULPI controller's register port. Provides a small local register set (ID, status, scratch) plus a 64-register window mapped 1:1 onto ULPI register addresses, with a per-access timeout so a stalled PHY cannot hang the debug bus.

## Interface
- `TIMEOUT_CYCLES`, 1023: cycles to wait for `reg_ack` before aborting with SLVERR; legal range 1..65535.
- `ID_VALUE`, 32'h554C_5049: constant returned at ID register.
- `aclk  in  1`: single clock. Same clock as the ULPI register port.
- `aresetn  in  1`: asynchronous, active-low reset.
- `s_axi_*  AXI4-Lite slave`: 32-bit address, 32-bit data, 4-bit `wstrb`, 2-bit `bresp`/`rresp`; `awprot`/`arprot` ignored.
- `reg_req  out  1`: ULPI register access request; held until `reg_ack` or timeout.
- `reg_we  out  1`: 1 = write, 0 = read; stable while `reg_req`.
- `reg_addr  out  6`: ULPI register address; stable while `reg_req`.
- `reg_wdata  out  8`: write data; stable while `reg_req`.
- `reg_ack  in  1`: one-cycle completion strobe from the ULPI controller.
- `reg_rdata  in  8`: read data, valid in the `reg_ack` cycle.

## Operation
- Address decode on `addr[11:0]`; `addr[1:0]` ignored. 0x000 ID (RO), 0x004 STATUS (RO: bit0 busy, bits15:8 timeout count), 0x008 SCRATCH (RW, byte strobes honoured), 0x100–0x1FC ULPI window (`reg_addr = addr[7:2]`). Anything else: DECERR; writes have no effect, reads return 0.
- ULPI window write: `reg_wdata = wdata[7:0]`; if `wstrb[0]=0`, no ULPI access, OKAY. Window read returns `{24'h0, reg_rdata}`.
- FSM states: IDLE, ULPI, BRESP, RRESP.
  - IDLE: if `awvalid && wvalid`, assert `awready`/`wready` for one cycle, latch address/data/strobe. Local or DECERR → BRESP; window → ULPI with `reg_we=1`. Else if `arvalid`, assert `arready` for one cycle; local/DECERR → RRESP; window → ULPI with `reg_we=0`.
  - Write has priority when both write and read are presented in the same cycle. AW and W arriving in different cycles are not accepted until both are valid.
  - ULPI: `reg_req=1`, and the cycle counter increments. On `reg_ack`: OKAY, latch `reg_rdata`, go to BRESP or RRESP. If the counter reaches `TIMEOUT_CYCLES` first: drop `reg_req`, SLVERR, go to BRESP or RRESP with read data 0, and increment the timeout count (saturates at 255).
  - `reg_ack` in the same cycle as expiry counts as success.
  - BRESP: `bvalid=1` until `bready`, then IDLE. RRESP: `rvalid=1` until `rready`, then IDLE.
- STATUS busy = FSM not IDLE. It always reads 0 through the bus, because a STATUS read is itself the transaction in flight.
- `reg_ack` outside the ULPI state is ignored.

## Timing
- Reset values: all ready/valid outputs 0, `bresp`/`rresp` 0, `rdata` 0, `reg_req` 0, `reg_we` 0, `reg_addr` 0, `reg_wdata` 0, SCRATCH 0, timeout count 0, FSM IDLE.
- Ready signals are registered. Acceptance happens on the first edge where valid and ready are both high.
- Local access: `bvalid`/`rvalid` rises 1 cycle after the handshake cycle.
- ULPI access: `reg_req` rises 1 cycle after the handshake. `bvalid`/`rvalid` rises 1 cycle after `reg_ack`, or 1 cycle after the expiry cycle.
- Timeout: `reg_req` is high for exactly `TIMEOUT_CYCLES` cycles when no ack arrives.
- One outstanding transaction at a time. No new ready is asserted while `bvalid` or `rvalid` is high.
- Reset asserted mid-transaction: immediate return to reset values. No response is issued for the aborted access.

## Structure
- Package `ulpi_csr_pkg`:
  - Register offsets.
  - Response codes OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - FSM state enum.
- Single module, no sub-modules. The timeout counter and decode are inline.

## Test plan
- After reset, read 0x000 → `rdata`=0x554C5049, OKAY, `rvalid` 1 cycle after `arready`. Then read 0x004 → 0.
- Write 0x008 data 0xAABBCCDD with `wstrb`=4'b0101, then read it back → 0x00BB00DD.
- Write 0x128 data 0x5A, with the model acking 3 cycles after `reg_req` → `reg_addr`=0x0A, `reg_we`=1, `reg_wdata`=0x5A, `bresp` OKAY. Then read 0x128, model returning 0x5A → `rdata`=0x0000005A.
- Read 0x104 with no ack and `TIMEOUT_CYCLES`=8 → `reg_req` high for 8 cycles, SLVERR, `rdata`=0. STATUS[15:8] then reads 1.
- Write and read presented in the same cycle → the write completes first, then the read. Read of 0x200 → DECERR with `rdata`=0.
- Deassert `aresetn` while `reg_req` is high → `reg_req` drops asynchronously and no `bvalid` is produced. A subsequent access works normally.
